// File: rtl/serdes_link_ctrl.sv
// serdes_link_ctrl
//   Brings up a SERDES link and supervises it once it is up. The block
//   resets the transceiver, waits for its reset-done flags, then enables
//   comma alignment until it sees a run of clean cycles. While the link is
//   locked it counts error cycles and restarts the link when needed. A
//   bounded number of consecutive failed attempts parks the block in FAULT.
//
// Ports
//   ref_clk            : sole clock, rising edge
//   trx_rstn_i         : async active-low reset (release synchronized outside)
//   enable_i           : link enable (ref_clk domain)
//   tx/rx_reset_done_i : SERDES reset-done flags (async, synchronized here)
//   rx_byte_aligned_i  : comma alignment status (async, synchronized here)
//   rx/tx_buf_err_i    : SERDES buffer errors (async, synchronized here)
//   rx_not_in_table_i  : per-byte 8b/10b code error (ref_clk domain)
//   rx_disp_err_i      : per-byte disparity error (ref_clk domain)
//   clr_cnt_i          : clears err_cnt_o; wins over a same-cycle increment
//   trx_rst_o          : SERDES TX/RX/PLL reset
//   comma_align_en_o   : comma detect / align enables
//   link_up_o          : link locked
//   fault_o            : retry budget exhausted
//   state_o            : current state code
//   retry_cnt_o        : consecutive failed attempts (saturates at 255)
//   err_cnt_o          : cumulative locked error cycles (saturates at 16'hFFFF)
//
// State table
//   state     | code | meaning
//   IDLE      |  0   | disabled, transceiver held in reset
//   RESET     |  1   | transceiver reset pulse, RST_CYCLES long
//   WAIT_DONE |  2   | waiting for TX and RX reset-done
//   ALIGN     |  3   | comma alignment, counting consecutive clean cycles
//   LOCKED    |  4   | link up, counting error cycles
//   FAULT     |  5   | too many failed attempts, waits for enable_i=0

module serdes_link_ctrl #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned DONE_TIMEOUT  = 65535,
    parameter int unsigned ALIGN_TIMEOUT = 65535,
    parameter int unsigned GOOD_CNT      = 256,
    parameter int unsigned ERR_THRESH    = 16,
    parameter int unsigned MAX_RETRIES   = 8
) (
    input  logic        ref_clk,
    input  logic        trx_rstn_i,
    input  logic        enable_i,
    input  logic        tx_reset_done_i,
    input  logic        rx_reset_done_i,
    input  logic        rx_byte_aligned_i,
    input  logic        rx_buf_err_i,
    input  logic        tx_buf_err_i,
    input  logic [7:0]  rx_not_in_table_i,
    input  logic [7:0]  rx_disp_err_i,
    input  logic        clr_cnt_i,
    output logic        trx_rst_o,
    output logic        comma_align_en_o,
    output logic        link_up_o,
    output logic        fault_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_cnt_o,
    output logic [15:0] err_cnt_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_ALIGN     = 3'd3,
        ST_LOCKED    = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

    // ---------------------------------------------------------------
    // Two-flop synchronizers: {tx_done, rx_done, aligned, rx_buf, tx_buf}
    // ---------------------------------------------------------------
    logic [4:0] async_in;
    logic [4:0] sync1_q;
    logic [4:0] sync2_q;

    assign async_in = {tx_reset_done_i, rx_reset_done_i, rx_byte_aligned_i,
                       rx_buf_err_i, tx_buf_err_i};

    always_ff @(posedge ref_clk or negedge trx_rstn_i) begin
        if (!trx_rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
        end
    end

    logic tx_done_s, rx_done_s, aligned_s, rx_buf_err_s, tx_buf_err_s;
    assign {tx_done_s, rx_done_s, aligned_s, rx_buf_err_s, tx_buf_err_s} = sync2_q;

    // ---------------------------------------------------------------
    // FSM and counters
    // ---------------------------------------------------------------
    state_e      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;     // down-counter, terminal count = 0
    logic [31:0] good_q, good_d;   // consecutive clean ALIGN cycles
    logic [31:0] win_q, win_d;     // error cycles since LOCKED entry
    logic [7:0]  retry_q, retry_d;
    logic [15:0] err_q, err_d;
    logic        trx_rst_q, trx_rst_d;
    logic        align_en_q, align_en_d;
    logic        link_up_q, link_up_d;
    logic        fault_q, fault_d;

    logic err_cycle;
    logic clean;
    logic do_retry;

    assign err_cycle = (|rx_not_in_table_i) | (|rx_disp_err_i);
    assign clean     = aligned_s & ~err_cycle & ~rx_buf_err_s & ~tx_buf_err_s;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        good_d   = good_q;
        win_d    = win_q;
        retry_d  = retry_q;
        err_d    = err_q;
        do_retry = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_RESET;
                    retry_d = '0;
                    tmr_d   = RST_CYCLES - 1;
                end
            end
            ST_RESET: begin
                if (tmr_q == '0) begin
                    state_d = ST_WAIT_DONE;
                    tmr_d   = DONE_TIMEOUT - 1;
                end else begin
                    tmr_d = tmr_q - 1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done_s && rx_done_s) begin
                    state_d = ST_ALIGN;
                    tmr_d   = ALIGN_TIMEOUT - 1;
                    good_d  = '0;
                end else if (tmr_q == '0) begin
                    do_retry = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1;
                end
            end
            ST_ALIGN: begin
                // Reaching the clean-run target wins over a same-cycle timeout.
                if (clean && (good_q + 32'd1 == GOOD_CNT)) begin
                    state_d = ST_LOCKED;
                    retry_d = '0;
                    win_d   = '0;
                end else begin
                    good_d = clean ? good_q + 32'd1 : '0;
                    if (tmr_q == '0) begin
                        do_retry = 1'b1;
                    end else begin
                        tmr_d = tmr_q - 1;
                    end
                end
            end
            ST_LOCKED: begin
                if (err_cycle) begin
                    win_d = win_q + 32'd1;
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                end
                if (!aligned_s || rx_buf_err_s || tx_buf_err_s || (win_q == ERR_THRESH)) begin
                    do_retry = 1'b1;
                end
            end
            ST_FAULT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_retry) begin
            retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
            if (32'(retry_q) + 32'd1 == MAX_RETRIES) begin
                state_d = ST_FAULT;
            end else begin
                state_d = ST_RESET;
                tmr_d   = RST_CYCLES - 1;
            end
        end

        if (clr_cnt_i) begin
            err_d = '0;
        end

        if (!enable_i) begin
            state_d = ST_IDLE;
        end

        // Outputs are registered from the next state so they line up with state_o.
        trx_rst_d  = (state_d == ST_IDLE) || (state_d == ST_RESET) || (state_d == ST_FAULT);
        align_en_d = (state_d == ST_ALIGN);
        link_up_d  = (state_d == ST_LOCKED);
        fault_d    = (state_d == ST_FAULT);
    end

    always_ff @(posedge ref_clk or negedge trx_rstn_i) begin
        if (!trx_rstn_i) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            good_q     <= '0;
            win_q      <= '0;
            retry_q    <= '0;
            err_q      <= '0;
            trx_rst_q  <= 1'b1;
            align_en_q <= 1'b0;
            link_up_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            good_q     <= good_d;
            win_q      <= win_d;
            retry_q    <= retry_d;
            err_q      <= err_d;
            trx_rst_q  <= trx_rst_d;
            align_en_q <= align_en_d;
            link_up_q  <= link_up_d;
            fault_q    <= fault_d;
        end
    end

    assign trx_rst_o        = trx_rst_q;
    assign comma_align_en_o = align_en_q;
    assign link_up_o        = link_up_q;
    assign fault_o          = fault_q;
    assign state_o          = state_q;
    assign retry_cnt_o      = retry_q;
    assign err_cnt_o        = err_q;

endmodule

// File: tb/tb_serdes_link_ctrl.sv
module tb_serdes_link_ctrl;

    logic        ref_clk = 1'b0;
    logic        trx_rstn_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        tx_reset_done_i = 1'b0;
    logic        rx_reset_done_i = 1'b0;
    logic        rx_byte_aligned_i = 1'b0;
    logic        rx_buf_err_i = 1'b0;
    logic        tx_buf_err_i = 1'b0;
    logic [7:0]  rx_not_in_table_i = 8'h00;
    logic [7:0]  rx_disp_err_i = 8'h00;
    logic        clr_cnt_i = 1'b0;
    logic        trx_rst_o;
    logic        comma_align_en_o;
    logic        link_up_o;
    logic        fault_o;
    logic [2:0]  state_o;
    logic [7:0]  retry_cnt_o;
    logic [15:0] err_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0] exp_q[$];
    logic [7:0] exp_r[$];
    logic [2:0] prev;
    logic [2:0] e_state;
    logic [7:0] e_retry;

    serdes_link_ctrl #(
        .RST_CYCLES(4), .DONE_TIMEOUT(100), .ALIGN_TIMEOUT(200),
        .GOOD_CNT(8), .ERR_THRESH(4), .MAX_RETRIES(3)
    ) dut (
        .ref_clk(ref_clk), .trx_rstn_i(trx_rstn_i), .enable_i(enable_i),
        .tx_reset_done_i(tx_reset_done_i), .rx_reset_done_i(rx_reset_done_i),
        .rx_byte_aligned_i(rx_byte_aligned_i), .rx_buf_err_i(rx_buf_err_i),
        .tx_buf_err_i(tx_buf_err_i), .rx_not_in_table_i(rx_not_in_table_i),
        .rx_disp_err_i(rx_disp_err_i), .clr_cnt_i(clr_cnt_i),
        .trx_rst_o(trx_rst_o), .comma_align_en_o(comma_align_en_o),
        .link_up_o(link_up_o), .fault_o(fault_o), .state_o(state_o),
        .retry_cnt_o(retry_cnt_o), .err_cnt_o(err_cnt_o)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic test_reset();
        trx_rstn_i = 1'b0;
        repeat (2) @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd0)       begin n_bad++; $display("FAIL rst_state got %0d want 0", state_o); end
        n_cmp++; if (trx_rst_o !== 1'b1)     begin n_bad++; $display("FAIL rst_trx_rst got %b want 1", trx_rst_o); end
        n_cmp++; if (comma_align_en_o !== 1'b0) begin n_bad++; $display("FAIL rst_align_en got %b want 0", comma_align_en_o); end
        n_cmp++; if (link_up_o !== 1'b0)     begin n_bad++; $display("FAIL rst_link_up got %b want 0", link_up_o); end
        n_cmp++; if (fault_o !== 1'b0)       begin n_bad++; $display("FAIL rst_fault got %b want 0", fault_o); end
        n_cmp++; if (retry_cnt_o !== 8'd0)   begin n_bad++; $display("FAIL rst_retry got %0d want 0", retry_cnt_o); end
        n_cmp++; if (err_cnt_o !== 16'd0)    begin n_bad++; $display("FAIL rst_err got %0d want 0", err_cnt_o); end
        trx_rstn_i = 1'b1;
        repeat (2) @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd0)       begin n_bad++; $display("FAIL idle_hold got %0d want 0", state_o); end
    endtask

    // Nominal bring-up: done rises 10 cycles after enable, data clean throughout.
    task automatic test_bringup();
        int rst_len = 0;
        int align_len = 0;
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
        prev = state_o;
        rx_byte_aligned_i = 1'b1;
        enable_i = 1'b1;
        for (int cyc = 1; cyc <= 300 && exp_q.size() > 0; cyc++) begin
            @(negedge ref_clk);
            if (cyc == 10) begin tx_reset_done_i = 1'b1; rx_reset_done_i = 1'b1; end
            if (state_o == 3'd1 && trx_rst_o) rst_len++;
            if (state_o == 3'd3) align_len++;
            if (state_o != prev) begin
                e_state = exp_q.pop_front();
                n_cmp++; if (state_o !== e_state) begin n_bad++; $display("FAIL bringup_seq got %0d want %0d", state_o, e_state); end
                if (state_o == 3'd2) begin
                    n_cmp++; if (trx_rst_o !== 1'b0) begin n_bad++; $display("FAIL wait_done_trx_rst got %b want 0", trx_rst_o); end
                end
                prev = state_o;
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bringup_timeout pending %0d want 0", exp_q.size()); end
        exp_q.delete();
        n_cmp++; if (rst_len != 4)          begin n_bad++; $display("FAIL bringup_rst_len got %0d want 4", rst_len); end
        n_cmp++; if (align_len != 8)        begin n_bad++; $display("FAIL bringup_align_len got %0d want 8", align_len); end
        n_cmp++; if (link_up_o !== 1'b1)    begin n_bad++; $display("FAIL bringup_link_up got %b want 1", link_up_o); end
        n_cmp++; if (comma_align_en_o !== 1'b0) begin n_bad++; $display("FAIL bringup_align_en got %b want 0", comma_align_en_o); end
        n_cmp++; if (retry_cnt_o !== 8'd0)  begin n_bad++; $display("FAIL bringup_retry got %0d want 0", retry_cnt_o); end
    endtask

    // Four disparity-error cycles in LOCKED force a relink; then counter clear.
    task automatic test_lock_errors();
        int k;
        rx_disp_err_i = 8'h01;
        repeat (4) @(negedge ref_clk);
        rx_disp_err_i = 8'h00;
        n_cmp++; if (err_cnt_o !== 16'd4) begin n_bad++; $display("FAIL err_cnt4 got %0d want 4", err_cnt_o); end
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_r = '{8'd1, 8'd1, 8'd1, 8'd0};
        prev = state_o;
        for (k = 0; k < 100 && exp_q.size() > 0; k++) begin
            @(negedge ref_clk);
            if (state_o != prev) begin
                e_state = exp_q.pop_front();
                e_retry = exp_r.pop_front();
                n_cmp++; if (state_o !== e_state) begin n_bad++; $display("FAIL relink_seq got %0d want %0d", state_o, e_state); end
                n_cmp++; if (retry_cnt_o !== e_retry) begin n_bad++; $display("FAIL relink_retry got %0d want %0d", retry_cnt_o, e_retry); end
                prev = state_o;
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL relink_timeout pending %0d want 0", exp_q.size()); end
        exp_q.delete(); exp_r.delete();
        n_cmp++; if (err_cnt_o !== 16'd4) begin n_bad++; $display("FAIL err_hold got %0d want 4", err_cnt_o); end
        rx_not_in_table_i = 8'h80;
        @(negedge ref_clk);
        rx_not_in_table_i = 8'h00;
        n_cmp++; if (err_cnt_o !== 16'd5) begin n_bad++; $display("FAIL err_cnt5 got %0d want 5", err_cnt_o); end
        rx_disp_err_i = 8'h01; clr_cnt_i = 1'b1;
        @(negedge ref_clk);
        rx_disp_err_i = 8'h00; clr_cnt_i = 1'b0;
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_bad++; $display("FAIL err_clr got %0d want 0", err_cnt_o); end
        n_cmp++; if (link_up_o !== 1'b1)  begin n_bad++; $display("FAIL still_locked got %b want 1", link_up_o); end
    endtask

    // Loss of alignment relinks; in ALIGN an unclean 8th cycle restarts the run.
    task automatic test_align_restart();
        int k;
        rx_byte_aligned_i = 1'b0;
        for (k = 0; k < 20 && state_o == 3'd4; k++) @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd1)     begin n_bad++; $display("FAIL unalign_state got %0d want 1", state_o); end
        n_cmp++; if (retry_cnt_o !== 8'd1) begin n_bad++; $display("FAIL unalign_retry got %0d want 1", retry_cnt_o); end
        rx_byte_aligned_i = 1'b1;
        for (k = 0; k < 50 && state_o != 3'd3; k++) @(negedge ref_clk);
        k = 0;
        while (state_o == 3'd3 && k < 60) begin
            rx_not_in_table_i = (k == 7) ? 8'h04 : 8'h00;
            @(negedge ref_clk);
            k++;
        end
        rx_not_in_table_i = 8'h00;
        n_cmp++; if (k != 16)              begin n_bad++; $display("FAIL align_restart_len got %0d want 16", k); end
        n_cmp++; if (state_o !== 3'd4)     begin n_bad++; $display("FAIL align_restart_state got %0d want 4", state_o); end
        n_cmp++; if (retry_cnt_o !== 8'd0) begin n_bad++; $display("FAIL align_restart_retry got %0d want 0", retry_cnt_o); end
    endtask

    // Async reset mid-LOCKED, with enable held high throughout.
    task automatic test_async_reset();
        rx_disp_err_i = 8'h10;
        @(negedge ref_clk);
        rx_disp_err_i = 8'h00;
        n_cmp++; if (err_cnt_o !== 16'd1) begin n_bad++; $display("FAIL pre_rst_err got %0d want 1", err_cnt_o); end
        #2 trx_rstn_i = 1'b0;
        #1;
        n_cmp++; if (state_o !== 3'd0)    begin n_bad++; $display("FAIL arst_state got %0d want 0", state_o); end
        n_cmp++; if (trx_rst_o !== 1'b1)  begin n_bad++; $display("FAIL arst_trx_rst got %b want 1", trx_rst_o); end
        n_cmp++; if (link_up_o !== 1'b0)  begin n_bad++; $display("FAIL arst_link_up got %b want 0", link_up_o); end
        n_cmp++; if (err_cnt_o !== 16'd0) begin n_bad++; $display("FAIL arst_err got %0d want 0", err_cnt_o); end
        n_cmp++; if (comma_align_en_o !== 1'b0 || fault_o !== 1'b0 || retry_cnt_o !== 8'd0) begin
            n_bad++; $display("FAIL arst_misc got %b/%b/%0d want 0/0/0", comma_align_en_o, fault_o, retry_cnt_o);
        end
        @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd0)    begin n_bad++; $display("FAIL arst_hold got %0d want 0", state_o); end
        trx_rstn_i = 1'b1;
        @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd1)    begin n_bad++; $display("FAIL arst_release got %0d want 1", state_o); end
    endtask

    // Done never arrives: three 100-cycle timeouts, then FAULT until disabled.
    task automatic test_fault();
        int dwell = 0;
        enable_i = 1'b0;
        @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL disable_state got %0d want 0", state_o); end
        tx_reset_done_i = 1'b0; rx_reset_done_i = 1'b0;
        repeat (3) @(negedge ref_clk);
        exp_q = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2, 3'd5};
        exp_r = '{8'd0, 8'd1, 8'd2, 8'd3};
        prev = state_o;
        enable_i = 1'b1;
        for (int cyc = 0; cyc < 600 && exp_q.size() > 0; cyc++) begin
            @(negedge ref_clk);
            if (state_o == 3'd2) dwell++;
            if (state_o != prev) begin
                e_state = exp_q.pop_front();
                n_cmp++; if (state_o !== e_state) begin n_bad++; $display("FAIL fault_seq got %0d want %0d", state_o, e_state); end
                if (prev == 3'd2) begin
                    n_cmp++; if (dwell != 100) begin n_bad++; $display("FAIL done_timeout_dwell got %0d want 100", dwell); end
                    dwell = 0;
                end
                if (state_o == 3'd1 || state_o == 3'd5) begin
                    e_retry = exp_r.pop_front();
                    n_cmp++; if (retry_cnt_o !== e_retry) begin n_bad++; $display("FAIL fault_retry got %0d want %0d", retry_cnt_o, e_retry); end
                end
                prev = state_o;
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL fault_timeout pending %0d want 0", exp_q.size()); end
        exp_q.delete(); exp_r.delete();
        repeat (5) @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd5)   begin n_bad++; $display("FAIL fault_hold got %0d want 5", state_o); end
        n_cmp++; if (fault_o !== 1'b1)   begin n_bad++; $display("FAIL fault_flag got %b want 1", fault_o); end
        n_cmp++; if (trx_rst_o !== 1'b1) begin n_bad++; $display("FAIL fault_trx_rst got %b want 1", trx_rst_o); end
        enable_i = 1'b0;
        @(negedge ref_clk);
        n_cmp++; if (state_o !== 3'd0)   begin n_bad++; $display("FAIL fault_exit got %0d want 0", state_o); end
        n_cmp++; if (fault_o !== 1'b0)   begin n_bad++; $display("FAIL fault_clear got %b want 0", fault_o); end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_lock_errors();
        test_align_restart();
        test_async_reset();
        test_fault();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
